fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage for the 4-bit-address microprocessor. The block holds the program counter and drives the program ROM's address and active-low output enable. It captures each returned byte into the instruction register and resolves control-flow opcodes (bun, call, ret, halt) locally. Data-path opcodes (lda, add, sub, out and all others) are issued to the execute stage over a valid/ready handshake.

## Interface
Parameters:
- ADDR_W, 4, PC / ROM address width
- DATA_W, 8, instruction width; opcode = [7:4], operand = [3:0]
- STACK_DEPTH, 4, return-address entries (only with CALL_STACK_EN)

Ports:
- CLK  in  1  system clock, rising edge
- RST_LOW  in  1  reset, asynchronous, active-low
- ROM_ADDR  out  ADDR_W  registered address to ROM
- ROM_LOW_OE  out  1  ROM output enable, active-low
- ROM_DATA  in  DATA_W  ROM data; high-Z whenever ROM_LOW_OE=1
- IR_OPCODE  out  4  issued opcode
- IR_OPERAND  out  4  issued operand
- IR_VALID  out  1  issued instruction valid
- EXE_READY  in  1  execute stage accepts the instruction
- PC  out  ADDR_W  current program counter
- HALTED  out  1  sticky; set on halt or stack error
- STACK_ERR  out  1  sticky; call overflow or ret underflow

## Operation
- Opcodes: 0 lda, 1 add, 2 sub, 5 bun, 6 call, 7 ret, 8 out, F halt; all others are issued unchanged.
- States: S_IDLE (reset), S_FETCH, S_DECODE, S_ISSUE, S_HALT.
- S_IDLE -> S_FETCH unconditionally on the first clock after reset release.
- S_FETCH: ROM_LOW_OE=0, ROM_ADDR=PC; the edge leaving the state latches ROM_DATA into IR and sets PC <= PC+1 mod 16. Always -> S_DECODE.
- S_DECODE:
  - bun: PC <= operand -> S_FETCH.
  - call: push the incremented PC, PC <= operand -> S_FETCH.
  - ret: pop into PC -> S_FETCH.
  - halt: -> S_HALT.
  - other: -> S_ISSUE.
- S_ISSUE: IR_VALID=1; IR_OPCODE and IR_OPERAND stable until IR_VALID && EXE_READY is sampled high, then -> S_FETCH.
- S_HALT: terminal; only reset exits. ROM_LOW_OE=1, IR_VALID=0.
- Stack boundaries:
  - call with stack full: STACK_ERR=1, no push, -> S_HALT.
  - ret with stack empty: STACK_ERR=1, -> S_HALT.
- PC wraps 0xF -> 0x0 with no flag.

## Timing
- Reset values: ROM_ADDR=0, ROM_LOW_OE=1, IR_OPCODE=0, IR_OPERAND=0, IR_VALID=0, PC=0, HALTED=0, STACK_ERR=0, stack empty.
- ROM_LOW_OE is driven low only during S_FETCH. The ROM is combinational, so data is sampled in the same cycle.
- Latency, fetch to IR_VALID: 2 cycles (FETCH, DECODE). Minimum issue rate is one instruction per 3 cycles with EXE_READY held high.
- Control-flow instructions take 2 cycles and are never issued.
- EXE_READY is ignored outside S_ISSUE.
- Reset asserted mid-operation forces S_IDLE within the same cycle (asynchronous). IR_VALID drops and ROM_LOW_OE rises immediately.

## Configuration
- CALL_STACK_EN defined: return-address stack is instantiated; call/ret behave as above.
- CALL_STACK_EN undefined: no stack logic; opcodes 6 and 7 are issued to execute like data ops; STACK_ERR is tied 0.

## Structure
- Package fetch_pkg holds:
  - opcode constants OP_LDA, OP_ADD, OP_SUB, OP_BUN, OP_CALL, OP_RET, OP_OUT, OP_HLT;
  - the state enum;
  - ADDR_W and DATA_W defaults.
- Sub-module call_stack: LIFO of STACK_DEPTH × ADDR_W with push, pop, full and empty. Push and pop are never asserted together.

## Test plan
- Reset: hold RST_LOW=0 -> all outputs at their reset values, ROM_LOW_OE=1. Release -> first ROM_LOW_OE=0 with ROM_ADDR=0 on cycle 2.
- Straight line: ROM[0]=0x08, EXE_READY low for 3 cycles -> IR_VALID=1 with opcode 0, operand 8 held stable. After accept, next fetch has ROM_ADDR=1.
- Branch: ROM[6]=0x50 -> no IR_VALID; next fetch ROM_ADDR=0.
- Call/ret: ROM[5]=0x6C, ROM[C..E]=0x0F,0x88,0x70 -> fetch order 5, C, D, E, 6. ret is never issued.
- Overflow: five nested calls with STACK_DEPTH=4 -> STACK_ERR=1 and HALTED=1 on the fifth call. Ret on empty stack -> the same flags.
- Halt and wrap: ROM[F]=0xFF -> HALTED=1 with no further ROM_LOW_OE=0. With ROM[F]=0x08, the next fetch after issue is ROM_ADDR=0.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : fetch_pkg                                               |
// | Purpose  : Shared opcodes, FSM state encodings and default widths  |
// |            for the instruction fetch stage.                        |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package fetch_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;

  // Opcodes live in instruction bits [7:4]
  localparam logic [3:0] OP_LDA  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_BUN  = 4'h5;
  localparam logic [3:0] OP_CALL = 4'h6;
  localparam logic [3:0] OP_RET  = 4'h7;
  localparam logic [3:0] OP_OUT  = 4'h8;
  localparam logic [3:0] OP_HLT  = 4'hF;

  // Fetch FSM states
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_FETCH  = 3'd1;
  localparam state_t S_DECODE = 3'd2;
  localparam state_t S_ISSUE  = 3'd3;
  localparam state_t S_HALT   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/call_stack.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : call_stack                                              |
// | Purpose  : Return-address LIFO, DEPTH entries of WIDTH bits.       |
// | Ports    : clk_i, rst_ni (async, active-low), push_i / pop_i,      |
// |            data_i (pushed value), data_o (top of stack),           |
// |            full_o, empty_o                                         |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module call_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] top_idx;

  assign wr_idx  = IDX_W'(cnt_q);
  assign top_idx = IDX_W'(cnt_q - 1'b1);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  // Meaningless while empty; the caller checks empty_o before popping
  assign data_o  = mem_q[top_idx];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_i && !full_o) begin
      mem_q[wr_idx] <= data_i;
      cnt_q         <= cnt_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : fetch_unit                                              |
// | Purpose  : Instruction fetch stage. Holds the PC, reads the ROM,   |
// |            resolves bun/call/ret/halt locally and issues all other |
// |            opcodes to execute over a valid/ready handshake.        |
// | Ports    : CLK, RST_LOW (async, active-low)                        |
// |            ROM_ADDR, ROM_LOW_OE, ROM_DATA  - program ROM           |
// |            IR_OPCODE, IR_OPERAND, IR_VALID, EXE_READY - execute    |
// |            PC, HALTED, STACK_ERR           - status               |
// | Config   : CALL_STACK_EN - when defined, call/ret use a return     |
// |            stack; otherwise opcodes 6/7 are issued as data ops     |
// |            and STACK_ERR is tied low.                              |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int STACK_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST_LOW,
  output logic [ADDR_W-1:0] ROM_ADDR,
  output logic              ROM_LOW_OE,
  input  logic [DATA_W-1:0] ROM_DATA,
  output logic [3:0]        IR_OPCODE,
  output logic [3:0]        IR_OPERAND,
  output logic              IR_VALID,
  input  logic              EXE_READY,
  output logic [ADDR_W-1:0] PC,
  output logic              HALTED,
  output logic              STACK_ERR
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              stack_err_q, stack_err_d;

  logic [3:0] opcode;
  logic [3:0] operand;
  assign opcode  = ir_q[7:4];
  assign operand = ir_q[3:0];

`ifdef CALL_STACK_EN
  logic              stack_push;
  logic              stack_pop;
  logic              stack_full;
  logic              stack_empty;
  logic [ADDR_W-1:0] stack_top;

  // PC already points past the call when in DECODE, so it is the return address
  call_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_W)
  ) u_call_stack (
    .clk_i   (CLK),
    .rst_ni  (RST_LOW),
    .push_i  (stack_push),
    .pop_i   (stack_pop),
    .data_i  (pc_q),
    .data_o  (stack_top),
    .full_o  (stack_full),
    .empty_o (stack_empty)
  );
`else
  wire unused_stack_depth = (STACK_DEPTH > 0);
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    stack_err_d = stack_err_q;
`ifdef CALL_STACK_EN
    stack_push  = 1'b0;
    stack_pop   = 1'b0;
`endif
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        // Combinational ROM: data is valid in the same cycle OE is low
        ir_d    = ROM_DATA;
        pc_d    = pc_q + 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_BUN: begin
            pc_d    = ADDR_W'(operand);
            state_d = S_FETCH;
          end
`ifdef CALL_STACK_EN
          OP_CALL: begin
            if (stack_full) begin
              stack_err_d = 1'b1;
              state_d     = S_HALT;
            end else begin
              stack_push = 1'b1;
              pc_d       = ADDR_W'(operand);
              state_d    = S_FETCH;
            end
          end
          OP_RET: begin
            if (stack_empty) begin
              stack_err_d = 1'b1;
              state_d     = S_HALT;
            end else begin
              stack_pop = 1'b1;
              pc_d      = stack_top;
              state_d   = S_FETCH;
            end
          end
`endif
          OP_HLT:  state_d = S_HALT;
          default: state_d = S_ISSUE;
        endcase
      end
      S_ISSUE: begin
        if (EXE_READY) begin
          state_d = S_FETCH;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_LOW) begin
    if (!RST_LOW) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      stack_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      stack_err_q <= stack_err_d;
    end
  end

  // Outputs decode straight from registers so reset takes effect immediately
  assign ROM_ADDR   = pc_q;
  assign PC         = pc_q;
  assign ROM_LOW_OE = (state_q != S_FETCH);
  assign IR_VALID   = (state_q == S_ISSUE);
  assign IR_OPCODE  = opcode;
  assign IR_OPERAND = operand;
  assign HALTED     = (state_q == S_HALT);
  assign STACK_ERR  = stack_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_fetch_unit                                           |
// | Purpose  : Self-checking bench for fetch_unit. Expected fetch      |
// |            addresses and issued instructions are queued per        |
// |            program and popped by a monitor as the DUT produces     |
// |            them. Expectations follow CALL_STACK_EN.                |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_fetch_unit;

  logic       CLK = 1'b0;
  logic       RST_LOW = 1'b0;
  logic [3:0] ROM_ADDR;
  logic       ROM_LOW_OE;
  logic [7:0] ROM_DATA;
  logic [3:0] IR_OPCODE;
  logic [3:0] IR_OPERAND;
  logic       IR_VALID;
  logic       EXE_READY = 1'b0;
  logic [3:0] PC;
  logic       HALTED;
  logic       STACK_ERR;

  logic [7:0] rom [16];

  // Garbage while disabled so sampling outside FETCH would be visible
  assign ROM_DATA = ROM_LOW_OE ? 8'hEE : rom[ROM_ADDR];

  always #5 CLK = ~CLK;

  fetch_unit #(.ADDR_W(4), .DATA_W(8), .STACK_DEPTH(4)) dut (
    .CLK        (CLK),
    .RST_LOW    (RST_LOW),
    .ROM_ADDR   (ROM_ADDR),
    .ROM_LOW_OE (ROM_LOW_OE),
    .ROM_DATA   (ROM_DATA),
    .IR_OPCODE  (IR_OPCODE),
    .IR_OPERAND (IR_OPERAND),
    .IR_VALID   (IR_VALID),
    .EXE_READY  (EXE_READY),
    .PC         (PC),
    .HALTED     (HALTED),
    .STACK_ERR  (STACK_ERR)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard state
  int fetch_q[$];
  int issue_q[$];
  bit mon_en      = 1'b0;
  int extra_fetch = 0;
  int extra_issue = 0;
  bit hold_pend   = 1'b0;
  int hold_val    = 0;
  int stall_left  = 0;

  // Execute-stage model: forced stalls first, then random readiness
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (IR_VALID && stall_left > 0) begin
        EXE_READY  = 1'b0;
        stall_left = stall_left - 1;
      end else begin
        EXE_READY = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: fetch addresses, accepted instructions, hold stability
  always @(negedge CLK) begin
    if (mon_en && RST_LOW) begin
      if (!ROM_LOW_OE) begin
        if (fetch_q.size() > 0) check_eq("fetch_addr", int'(ROM_ADDR), fetch_q.pop_front());
        else extra_fetch++;
      end
      if (hold_pend) begin
        check_eq("hold_valid", int'(IR_VALID), 1);
        check_eq("hold_ir", int'({IR_OPCODE, IR_OPERAND}), hold_val);
      end
      if (IR_VALID && EXE_READY) begin
        if (issue_q.size() > 0) check_eq("issue", int'({IR_OPCODE, IR_OPERAND}), issue_q.pop_front());
        else extra_issue++;
      end
      hold_pend = IR_VALID && !EXE_READY;
      hold_val  = int'({IR_OPCODE, IR_OPERAND});
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'h30;
  endtask

  function automatic logic [3:0] data_op(input int i);
    case (i % 6)
      0: data_op = 4'h0;
      1: data_op = 4'h1;
      2: data_op = 4'h2;
      3: data_op = 4'h8;
      4: data_op = 4'h3;
      default: data_op = 4'hC;
    endcase
  endfunction

  // Resets, runs until the queues drain, then checks leftovers and flags
  task automatic run_prog(input string name, input int max_cycles, input bit strict,
                          input int exp_halt, input int exp_err);
    @(negedge CLK);
    mon_en  = 1'b0;
    RST_LOW = 1'b0;
    repeat (2) @(negedge CLK);
    extra_fetch = 0;
    extra_issue = 0;
    hold_pend   = 1'b0;
    mon_en      = 1'b1;
    RST_LOW     = 1'b1;
    for (int c = 0; c < max_cycles && (fetch_q.size() != 0 || issue_q.size() != 0); c++)
      @(posedge CLK);
    if (strict) repeat (12) @(posedge CLK);
    @(negedge CLK);
    #1;
    check_eq({name, "_fetch_left"}, fetch_q.size(), 0);
    check_eq({name, "_issue_left"}, issue_q.size(), 0);
    if (strict) begin
      check_eq({name, "_extra_fetch"}, extra_fetch, 0);
      check_eq({name, "_extra_issue"}, extra_issue, 0);
    end
    check_eq({name, "_halted"}, int'(HALTED), exp_halt);
    check_eq({name, "_stack_err"}, int'(STACK_ERR), exp_err);
    mon_en = 1'b0;
    fetch_q.delete();
    issue_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_rom();

    // ---------------- reset values ----------------
    repeat (3) @(negedge CLK);
    check_eq("rst_rom_addr", int'(ROM_ADDR), 0);
    check_eq("rst_oe", int'(ROM_LOW_OE), 1);
    check_eq("rst_opcode", int'(IR_OPCODE), 0);
    check_eq("rst_operand", int'(IR_OPERAND), 0);
    check_eq("rst_valid", int'(IR_VALID), 0);
    check_eq("rst_pc", int'(PC), 0);
    check_eq("rst_halted", int'(HALTED), 0);
    check_eq("rst_stack_err", int'(STACK_ERR), 0);
    RST_LOW = 1'b1;
    #1;
    check_eq("idle_oe", int'(ROM_LOW_OE), 1);
    @(negedge CLK);
    check_eq("first_fetch_oe", int'(ROM_LOW_OE), 0);
    check_eq("first_fetch_addr", int'(ROM_ADDR), 0);

    // ---------------- straight line + wrap ----------------
    for (int i = 0; i < 16; i++) rom[i] = {data_op(i), 4'(i)};
    rom[0]  = 8'h08;
    rom[15] = 8'h08;
    for (int i = 0; i < 16; i++) begin
      fetch_q.push_back(i);
      issue_q.push_back(int'(rom[i]));
    end
    fetch_q.push_back(0);
    fetch_q.push_back(1);
    issue_q.push_back(int'(rom[0]));
    stall_left = 3;
    run_prog("line", 300, 1'b0, 0, 0);

    // ---------------- unconditional branch ----------------
    clear_rom();
    for (int i = 0; i < 6; i++) rom[i] = {data_op(i + 1), 4'(i)};
    rom[6] = 8'h50;
    for (int i = 0; i < 7; i++) fetch_q.push_back(i);
    fetch_q.push_back(0);
    fetch_q.push_back(1);
    for (int i = 0; i < 6; i++) issue_q.push_back(int'(rom[i]));
    issue_q.push_back(int'(rom[0]));
    run_prog("bun", 200, 1'b0, 0, 0);

    // ---------------- call / ret ----------------
    clear_rom();
    for (int i = 0; i < 5; i++) rom[i] = {4'h1, 4'(i)};
    rom[5]  = 8'h6C;
    rom[6]  = 8'hFF;
    rom[12] = 8'h0F;
    rom[13] = 8'h88;
    rom[14] = 8'h70;
    for (int i = 0; i < 6; i++) fetch_q.push_back(i);
    for (int i = 0; i < 5; i++) issue_q.push_back(int'(rom[i]));
`ifdef CALL_STACK_EN
    fetch_q.push_back(12);
    fetch_q.push_back(13);
    fetch_q.push_back(14);
    issue_q.push_back(8'h0F);
    issue_q.push_back(8'h88);
`else
    issue_q.push_back(8'h6C);
`endif
    fetch_q.push_back(6);
    run_prog("callret", 200, 1'b1, 1, 0);

    // ---------------- call overflow ----------------
    clear_rom();
    for (int i = 0; i < 5; i++) rom[i] = {4'h6, 4'(i + 1)};
    rom[5] = 8'hFF;
    for (int i = 0; i < 5; i++) fetch_q.push_back(i);
`ifdef CALL_STACK_EN
    run_prog("overflow", 200, 1'b1, 1, 1);
`else
    fetch_q.push_back(5);
    for (int i = 0; i < 5; i++) issue_q.push_back(int'(rom[i]));
    run_prog("overflow", 200, 1'b1, 1, 0);
`endif

    // ---------------- ret on empty stack ----------------
    clear_rom();
    rom[0] = 8'h10;
    rom[1] = 8'h70;
    rom[2] = 8'hFF;
    fetch_q.push_back(0);
    fetch_q.push_back(1);
    issue_q.push_back(8'h10);
`ifdef CALL_STACK_EN
    run_prog("underflow", 200, 1'b1, 1, 1);
`else
    fetch_q.push_back(2);
    issue_q.push_back(8'h70);
    run_prog("underflow", 200, 1'b1, 1, 0);
`endif

    // ---------------- halt at top of ROM ----------------
    clear_rom();
    rom[0]  = 8'h5F;
    rom[15] = 8'hFF;
    fetch_q.push_back(0);
    fetch_q.push_back(15);
    run_prog("halt", 100, 1'b1, 1, 0);

    // ---------------- asynchronous reset mid-operation ----------------
    clear_rom();
    rom[0] = 8'h23;
    @(negedge CLK);
    RST_LOW = 1'b0;
    repeat (2) @(negedge CLK);
    RST_LOW    = 1'b1;
    stall_left = 4;
    for (int c = 0; c < 20 && !IR_VALID; c++) @(negedge CLK);
    check_eq("wait_valid", int'(IR_VALID), 1);
    check_eq("issue_ir", int'({IR_OPCODE, IR_OPERAND}), 8'h23);
    #2;
    RST_LOW = 1'b0;
    #1;
    check_eq("async_valid", int'(IR_VALID), 0);
    check_eq("async_oe", int'(ROM_LOW_OE), 1);
    check_eq("async_pc", int'(PC), 0);
    @(negedge CLK);
    RST_LOW = 1'b1;
    @(negedge CLK);
    check_eq("refetch_oe", int'(ROM_LOW_OE), 0);
    #2;
    RST_LOW = 1'b0;
    #1;
    check_eq("async_fetch_oe", int'(ROM_LOW_OE), 1);
    @(negedge CLK);
    RST_LOW = 1'b1;
    repeat (2) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
